tag_fifo: RTL
=============

Name: tag_fifo

Overview:
- Free-tag allocator for the Tomasulo rename path; it issues the 6-bit tags that dispatch writes into the register status table as {valid, tag}.
- Reclaims each tag when its result is broadcast on the CDB (cdb_valid/cdb_tag) and the status entry is cleared.
- Circular FIFO of free tags with first-word-fall-through read, so a tag is offered combinationally in the same cycle as the dispatch request.

Parameters:
- TAG_W, 6, tag width; matches the CDB and RST tag fields.
- DEPTH, 64, number of tags in circulation; must equal 2**TAG_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  dispatch requests one tag this cycle
- alloc_tag  out  TAG_W  tag at head of free list (FWFT)
- alloc_valid  out  1  free tag available (= !empty)
- cdb_valid  in  1  CDB broadcast valid; returns cdb_tag to the free list
- cdb_tag  in  TAG_W  tag being freed
- free_count  out  TAG_W+1  number of free tags held (0..DEPTH)
- full  out  1  free_count == DEPTH
- empty  out  1  free_count == 0
- tag_err  out  1  sticky error flag (see Optional Feature; tied 0 when feature absent)

Behaviour:
- Storage: DEPTH x TAG_W array mem; head pointer (read); tail pointer (write); free_count register. Both pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
- Reset (async, rst=1):
  - mem[i] = i for i = 0..DEPTH-1.
  - head = 0, tail = 0, free_count = DEPTH.
  - Outputs: alloc_tag = 0, alloc_valid = 1, full = 1, empty = 0, tag_err = 0.
- Reset asserted mid-operation: all state returns to the reset image; in-flight allocations are forgotten.
- Read path:
  - alloc_tag = mem[head], combinational.
  - alloc_valid = !empty.
- Pop: pop = alloc_req & !empty. On the clock edge, head <= head+1. Tag is consumed in the same cycle it is presented; zero latency.
- Push: push = cdb_valid & (!full | pop). On the clock edge, mem[tail] <= cdb_tag and tail <= tail+1.
- free_count update per cycle:
  - +1 for push only.
  - -1 for pop only.
  - unchanged for both or neither.
- Boundary conditions:
  - Pop when empty: ignored; alloc_valid=0, head unchanged. Dispatch must stall.
  - Push when full without pop: dropped; no state change; sets tag_err if the feature is enabled.
  - Push and pop together when full: both occur. Head and tail point to the same slot; the old value is read combinationally before the edge and the new value is written at the edge.
  - Push and pop together when empty: no bypass. Push occurs, pop ignored, alloc_valid stays 0 this cycle. The returned tag is available next cycle.
- full and empty are decoded from the registered free_count (glitch-free, one-cycle-accurate).
- At most one push and one pop per cycle (single CDB, single dispatch port).

Optional Feature:
- Macro: TAG_FIFO_CHECK_EN.
- With the macro defined:
  - Adds a DEPTH-bit in_use vector, reset to all 0.
  - Pop sets in_use[alloc_tag]; push clears in_use[cdb_tag].
  - tag_err is set (sticky until reset) on any of:
    - push of a tag whose in_use bit is 0 (double free or spurious CDB tag);
    - dropped push when full.
  - Simultaneous pop and push of the same tag value in one cycle is legal and leaves in_use at 0.
- Without the macro: no in_use vector; tag_err tied to 0; push-when-full is silently dropped.

Test Plan:
- Reset -> alloc_tag=0, alloc_valid=1, free_count=64, full=1, empty=0, tag_err=0.
- alloc_req high for 3 cycles -> alloc_tag 0,1,2 on successive cycles; free_count 63,62,61 after each edge; full=0.
- 64 consecutive pops -> tags 0..63 in order; then empty=1, alloc_valid=0. A 65th alloc_req leaves head and free_count unchanged.
- From empty:
  - push cdb_tag=5 and cdb_tag=9 on two cycles -> free_count=2, alloc_tag=5.
  - pop twice -> 5 then 9, wrap-around verified.
  - push+pop in one cycle while empty -> push only; free_count=1 next cycle.
- After reset (full), alloc_req=1 with cdb_valid=1 and cdb_tag=0 in the same cycle -> free_count stays 64, alloc_tag=1 next cycle. With TAG_FIFO_CHECK_EN, tag_err stays 0.
- With TAG_FIFO_CHECK_EN:
  - Pop tag 0, then push tag 0 twice -> first push clean; second sets tag_err=1 and it stays 1 until rst.
  - Assert rst mid-sequence -> tag_err=0, free_count=64, alloc_tag=0.

Source files
------------

// File: rtl/tag_fifo.sv
// Free-tag allocator: circular FWFT FIFO of rename tags, popped by dispatch and refilled from the CDB.
// Optional ownership checking (in_use vector + sticky tag_err) is enabled by defining TAG_FIFO_CHECK_EN.
module tag_fifo #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_valid,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic [TAG_W:0]   free_count,
    output logic             full,
    output logic             empty,
    output logic             tag_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             pop;
    logic             push;

    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign free_count  = count_q;
    assign alloc_tag   = mem_q[head_q];
    assign alloc_valid = !empty;

    // A full FIFO can still accept a returning tag when a pop frees the slot in the same cycle.
    assign pop  = alloc_req && !empty;
    assign push = cdb_valid && (!full || pop);

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            mem_d[tail_q] = cdb_tag;
            tail_d        = tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_W'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DEPTH_CNT;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef TAG_FIFO_CHECK_EN
    logic [DEPTH-1:0] in_use_q, in_use_d;
    logic             tag_err_q, tag_err_d;

    // Returning a tag that is being handed out this very cycle is legal, so the owner check
    // also accepts a match against the tag currently being popped.
    always_comb begin
        in_use_d  = in_use_q;
        tag_err_d = tag_err_q;
        if (cdb_valid && !push) begin
            tag_err_d = 1'b1;
        end
        if (push && !in_use_q[cdb_tag] && !(pop && (alloc_tag == cdb_tag))) begin
            tag_err_d = 1'b1;
        end
        if (pop) begin
            in_use_d[alloc_tag] = 1'b1;
        end
        if (push) begin
            in_use_d[cdb_tag] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_use_q  <= '0;
            tag_err_q <= 1'b0;
        end else begin
            in_use_q  <= in_use_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign tag_err = tag_err_q;
`else
    assign tag_err = 1'b0;
`endif

endmodule
